// File: rtl/id_ex_pipeline_register_if.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_register_if
// Bundle of everything crossing the decode -> execute boundary.
//
//   Hazard control : StallE, FlushE          (driven by the hazard unit)
//   D-side fields  : ValidD, RD1D, RD2D, Imm_ExtD, PCD, PCPlus4D,
//                    Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD,
//                    ALUSrcD, ResultSrcD, ALUControlD
//   E-side fields  : the same set with an E suffix, plus ValidE
//   Optional       : BubbleCntE, StallCntE (only when ID_EX_PERF_EN is defined)
//
// Modports:
//   master - the decode/hazard side: drives D fields and controls, reads E.
//   slave  - the pipeline register itself: reads D fields, drives E.
// -----------------------------------------------------------------------------
interface id_ex_pipeline_register_if #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALUCTL_W = 3
);
    // hazard control
    logic                StallE;
    logic                FlushE;

    // decode side
    logic                ValidD;
    logic [XLEN-1:0]     RD1D;
    logic [XLEN-1:0]     RD2D;
    logic [XLEN-1:0]     Imm_ExtD;
    logic [XLEN-1:0]     PCD;
    logic [XLEN-1:0]     PCPlus4D;
    logic [REG_AW-1:0]   Rs1D;
    logic [REG_AW-1:0]   Rs2D;
    logic [REG_AW-1:0]   RdD;
    logic                RegWriteD;
    logic                MemWriteD;
    logic                JumpD;
    logic                BranchD;
    logic                ALUSrcD;
    logic [1:0]          ResultSrcD;
    logic [ALUCTL_W-1:0] ALUControlD;

    // execute side
    logic                ValidE;
    logic [XLEN-1:0]     RD1E;
    logic [XLEN-1:0]     RD2E;
    logic [XLEN-1:0]     Imm_ExtE;
    logic [XLEN-1:0]     PCE;
    logic [XLEN-1:0]     PCPlus4E;
    logic [REG_AW-1:0]   Rs1E;
    logic [REG_AW-1:0]   Rs2E;
    logic [REG_AW-1:0]   RdE;
    logic                RegWriteE;
    logic                MemWriteE;
    logic                JumpE;
    logic                BranchE;
    logic                ALUSrcE;
    logic [1:0]          ResultSrcE;
    logic [ALUCTL_W-1:0] ALUControlE;

`ifdef ID_EX_PERF_EN
    logic [31:0]         BubbleCntE;
    logic [31:0]         StallCntE;
`endif

    modport master (
        output StallE, FlushE,
        output ValidD, RD1D, RD2D, Imm_ExtD, PCD, PCPlus4D,
        output Rs1D, Rs2D, RdD,
        output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
        output ResultSrcD, ALUControlD,
`ifdef ID_EX_PERF_EN
        input  BubbleCntE, StallCntE,
`endif
        input  ValidE, RD1E, RD2E, Imm_ExtE, PCE, PCPlus4E,
        input  Rs1E, Rs2E, RdE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        input  ResultSrcE, ALUControlE
    );

    modport slave (
        input  StallE, FlushE,
        input  ValidD, RD1D, RD2D, Imm_ExtD, PCD, PCPlus4D,
        input  Rs1D, Rs2D, RdD,
        input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
        input  ResultSrcD, ALUControlD,
`ifdef ID_EX_PERF_EN
        output BubbleCntE, StallCntE,
`endif
        output ValidE, RD1E, RD2E, Imm_ExtE, PCE, PCPlus4E,
        output Rs1E, Rs2E, RdE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
        output ResultSrcE, ALUControlE
    );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_register
// Decode-to-execute pipeline register of the 5-stage RISC-V core.
//
// Ports:
//   clk  - pipeline clock, all state changes on the rising edge
//   rst  - synchronous, active-low reset (highest priority)
//   bus  - id_ex_pipeline_register_if.slave: StallE/FlushE hazard controls,
//          D-stage fields in, registered E-stage fields out
//
// Per-edge priority: reset > FlushE > StallE > load.
//   * reset and flush both produce the all-zero bubble (data fields included,
//     so a bubble can never match a forwarding comparison).
//   * a load with ValidD=0 copies data but kills every side-effecting control
//     bit (RegWrite, MemWrite, Jump, Branch) and ValidE.
// All outputs come straight from flops; there is no input->output path.
// Fields are copied bit-exact; Imm_ExtE is never re-extended.
//
// Optional build macro: ID_EX_PERF_EN
//   Adds 32-bit wrapping counters BubbleCntE (edges inserting a bubble: flush,
//   or load with ValidD=0) and StallCntE (edges with StallE=1, FlushE=0).
// -----------------------------------------------------------------------------
module id_ex_pipeline_register #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALUCTL_W = 3
) (
    input  logic clk,
    input  logic rst,
    id_ex_pipeline_register_if.slave bus
);

    // Whole E-stage payload as one packed record so reset/flush/hold are a
    // single assignment each.
    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     rd1;
        logic [XLEN-1:0]     rd2;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     pc_plus4;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
        logic                reg_write;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic                alu_src;
        logic [1:0]          result_src;
        logic [ALUCTL_W-1:0] alu_ctl;
    } e_stage_t;

    e_stage_t r_e;
    e_stage_t w_load;

    logic w_flush;
    logic w_stall;
    logic w_valid;

    assign w_flush = bus.FlushE;
    assign w_stall = bus.StallE & ~bus.FlushE;
    assign w_valid = bus.ValidD;

    // Value captured on a normal load. Side-effecting controls are gated by
    // ValidD; pure data and selects are passed through untouched.
    always_comb begin
        w_load            = '0;
        w_load.valid      = w_valid;
        w_load.rd1        = bus.RD1D;
        w_load.rd2        = bus.RD2D;
        w_load.imm        = bus.Imm_ExtD;
        w_load.pc         = bus.PCD;
        w_load.pc_plus4   = bus.PCPlus4D;
        w_load.rs1        = bus.Rs1D;
        w_load.rs2        = bus.Rs2D;
        w_load.rd         = bus.RdD;
        w_load.reg_write  = bus.RegWriteD & w_valid;
        w_load.mem_write  = bus.MemWriteD & w_valid;
        w_load.jump       = bus.JumpD     & w_valid;
        w_load.branch     = bus.BranchD   & w_valid;
        w_load.alu_src    = bus.ALUSrcD;
        w_load.result_src = bus.ResultSrcD;
        w_load.alu_ctl    = bus.ALUControlD;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_e <= '0;
        end else if (w_flush) begin
            r_e <= '0;
        end else if (!w_stall) begin
            r_e <= w_load;
        end
    end

    assign bus.ValidE      = r_e.valid;
    assign bus.RD1E        = r_e.rd1;
    assign bus.RD2E        = r_e.rd2;
    assign bus.Imm_ExtE    = r_e.imm;
    assign bus.PCE         = r_e.pc;
    assign bus.PCPlus4E    = r_e.pc_plus4;
    assign bus.Rs1E        = r_e.rs1;
    assign bus.Rs2E        = r_e.rs2;
    assign bus.RdE         = r_e.rd;
    assign bus.RegWriteE   = r_e.reg_write;
    assign bus.MemWriteE   = r_e.mem_write;
    assign bus.JumpE       = r_e.jump;
    assign bus.BranchE     = r_e.branch;
    assign bus.ALUSrcE     = r_e.alu_src;
    assign bus.ResultSrcE  = r_e.result_src;
    assign bus.ALUControlE = r_e.alu_ctl;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_bubble;

    // A bubble enters E either by flush or by loading an invalid decode slot.
    assign w_bubble = w_flush | (~bus.StallE & ~w_valid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_stall)  r_stall_cnt  <= r_stall_cnt  + 32'd1;
        end
    end

    assign bus.BubbleCntE = r_bubble_cnt;
    assign bus.StallCntE  = r_stall_cnt;
`endif

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode-to-execute pipeline register of the 5-stage RISC-V core; sits directly downstream of the immediate sign-extender and the register file.
- Captures the 32-bit extended immediate, register operands, PC values, register indices and decode control each cycle, and presents them to the execute stage.
- Supports stall (hold), flush (bubble insert) and a valid bit, driven by the hazard unit.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- REG_AW, 5, register index width.
- ALUCTL_W, 3, ALU control width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- StallE  in  1  hold all E-stage contents.
- FlushE  in  1  replace E-stage contents with a bubble.
- ValidD  in  1  decode stage holds a real instruction.
- RD1D, RD2D  in  XLEN each  register-file read data.
- Imm_ExtD  in  XLEN  sign-extended immediate from the decode stage.
- PCD, PCPlus4D  in  XLEN each  instruction PC and PC+4.
- Rs1D, Rs2D, RdD  in  REG_AW each  source and destination indices.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control.
- ResultSrcD  in  2  result mux select.
- ALUControlD  in  ALUCTL_W  ALU operation.
- RD1E, RD2E, Imm_ExtE, PCE, PCPlus4E  out  XLEN each  registered copies.
- Rs1E, Rs2E, RdE  out  REG_AW each  registered indices.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each.
- ResultSrcE  out  2.
- ALUControlE  out  ALUCTL_W.
- ValidE  out  1  E-stage holds a real instruction.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low; it is sampled only on the rising edge of clk and has priority over everything else.
- Reset state: every output is 0. A zero state is a legal bubble: no register write, no memory write, no branch, no jump.
- Update priority per rising edge, highest first: reset, then FlushE, then StallE, then normal load.
- Normal load (rst=1, FlushE=0, StallE=0): all E outputs take the D inputs. Latency is exactly 1 cycle. ValidE takes ValidD.
- Stall (StallE=1, FlushE=0): all outputs hold their values, ValidE included.
- Flush (FlushE=1): all control outputs and ValidE go to 0. Data outputs (RD1E, RD2E, Imm_ExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE) also go to 0, so a bubble can never spuriously match a forwarding comparison.
- FlushE=1 together with StallE=1: flush wins and a bubble is inserted.
- Invalid input (ValidD=0 on a normal load): data is loaded, but RegWriteE, MemWriteE, JumpE, BranchE and ValidE are forced to 0.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: the next edge gives the all-zero state. After rst returns high, normal loading resumes on the first edge.
- Width rules: no arithmetic in this block; all fields are copied bit-exact. Imm_ExtE is never re-extended.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined:
  - Adds outputs BubbleCntE and StallCntE, 32 bits each.
  - BubbleCntE increments on every edge that inserts a bubble (flush, or a normal load with ValidD=0).
  - StallCntE increments on every edge where StallE=1 and FlushE=0.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: neither port nor counter logic exists; the block behaves identically otherwise.

Test Plan:
- Reset, then load: rst=0 for 2 cycles, then rst=1 with Imm_ExtD=32'hFFFFF800, RdD=5, RegWriteD=1, ValidD=1 -> outputs all 0 during reset; one edge later Imm_ExtE=32'hFFFFF800, RdE=5, RegWriteE=1, ValidE=1.
- Stall hold: load PCD=32'h100, then StallE=1 for 3 cycles while PCD=32'h104 -> PCE stays 32'h100 for all 3 cycles; becomes 32'h104 one edge after StallE drops.
- Flush over stall: E holds MemWriteE=1, RdE=7; apply FlushE=1 and StallE=1 together -> next edge gives MemWriteE=0, RdE=0, ValidE=0, all data 0.
- Invalid decode: ValidD=0, RegWriteD=1, BranchD=1, RD1D=32'hDEADBEEF -> RD1E=32'hDEADBEEF, RegWriteE=0, BranchE=0, ValidE=0.
- Sync reset mid-stream: rst=0 pulsed low with StallE=1 and non-zero contents -> all outputs 0 at that edge, not before it; normal load resumes on the next edge after rst=1.
- ID_EX_PERF_EN: 2 flush cycles plus 1 load with ValidD=0 -> BubbleCntE=3; 4 stall cycles -> StallCntE=4; a counter preset to 32'hFFFFFFFF wraps to 0 on its next increment.
